// File: rtl/uart_cipher_framer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cipher_framer
// Description : Byte-stream framer between a UART rx/tx pair and a
//               block-cipher core with a start/done handshake. Collects a
//               header byte, a message block and an optional key block
//               (CHUNK_BITS payload bits per rx byte), runs the cipher and
//               returns a status byte followed by the result, MSB byte first.
//               Protocol errors return a single error-code byte instead.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_rx_data     received byte          i_rx_valid   1-cycle rx strobe
//   o_tx_data     byte to transmit       o_tx_start   1-cycle tx strobe
//   i_tx_busy     transmitter busy
//   o_cph_in      cipher input block     o_cph_key    cipher key
//   o_cph_decrypt 1 = decrypt            o_cph_start  1-cycle cipher start
//   i_cph_done    1-cycle result strobe  i_cph_out    cipher result
//   o_key_valid   a key is held and may be reused
//   o_frame_err   1-cycle strobe on any protocol error
// ============================================================================
module uart_cipher_framer #(
  parameter int BLOCK_W     = 64,
  parameter int CHUNK_BITS  = 7,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CPH_WDOG    = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic [BLOCK_W-1:0] o_cph_in,
  output logic [BLOCK_W-1:0] o_cph_key,
  output logic               o_cph_decrypt,
  output logic               o_cph_start,
  input  logic               i_cph_done,
  input  logic [BLOCK_W-1:0] i_cph_out,
  output logic               o_key_valid,
  output logic               o_frame_err
);

  localparam int N_XFER  = (BLOCK_W + CHUNK_BITS - 1) / CHUNK_BITS;
  // Bits carried by the final transfer of a block.
  localparam int LAST_R  = BLOCK_W - (N_XFER - 1) * CHUNK_BITS;
  localparam int N_BYTES = BLOCK_W / 8;
  localparam int CW      = $clog2(CPH_WDOG + N_XFER + N_BYTES + 2);
  localparam int GW      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] C_LAST_XFER = CW'(N_XFER - 1);
  localparam logic [CW-1:0] C_WDOG_LAST = CW'(CPH_WDOG - 1);
  localparam logic [CW-1:0] C_RESP_LEN  = CW'(N_BYTES + 1);
  localparam logic [CW-1:0] C_ERR_LEN   = CW'(1);
  localparam logic [GW-1:0] C_TIMEOUT   = GW'(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_MSG  = 3'd1;
  localparam logic [2:0] S_RX_KEY  = 3'd2;
  localparam logic [2:0] S_CRYPT   = 3'd3;
  localparam logic [2:0] S_TX_RESP = 3'd4;
  localparam logic [2:0] S_TX_ERR  = 3'd5;

  logic [2:0]         r_state;
  logic [1:0]         r_mode;      // {reuse key, decrypt}
  logic [CW-1:0]      r_cnt;       // transfer index / watchdog / tx byte count
  logic [GW-1:0]      r_gap;
  logic [BLOCK_W-1:0] r_msg;       // message, then result during TX_RESP
  logic [BLOCK_W-1:0] r_key;
  logic               r_key_valid;
  logic [7:0]         r_err_code;
  logic               r_txph;      // 0: wait busy low then send, 1: wait busy high
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_cph_start;
  logic               r_frame_err;

  logic [BLOCK_W-1:0] w_src;
  logic [BLOCK_W-1:0] w_shifted;
  logic [CW-1:0]      w_tx_total;

  // Shift the next payload chunk into whichever block is being received;
  // the last transfer only carries LAST_R bits.
  assign w_src     = (r_state == S_RX_KEY) ? r_key : r_msg;
  assign w_shifted = (r_cnt == C_LAST_XFER)
                   ? {w_src[BLOCK_W-LAST_R-1:0], i_rx_data[LAST_R-1:0]}
                   : {w_src[BLOCK_W-CHUNK_BITS-1:0], i_rx_data[CHUNK_BITS-1:0]};
  assign w_tx_total = (r_state == S_TX_ERR) ? C_ERR_LEN : C_RESP_LEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_msg       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_err_code  <= 8'h00;
      r_txph      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_cph_start <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_cph_start <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && i_rx_data[7]) begin
            r_mode  <= i_rx_data[1:0];
            r_cnt   <= '0;
            r_gap   <= '0;
            r_state <= S_RX_MSG;
          end
        end
        S_RX_MSG, S_RX_KEY: begin
          if (i_rx_valid) begin
            r_gap <= '0;
            if (i_rx_data[7]) begin
              // Header inside a frame: restart with the new header.
              r_mode  <= i_rx_data[1:0];
              r_cnt   <= '0;
              r_state <= S_RX_MSG;
            end else begin
              if (r_state == S_RX_MSG) r_msg <= w_shifted;
              else                     r_key <= w_shifted;
              if (r_cnt == C_LAST_XFER) begin
                r_cnt <= '0;
                if (r_state == S_RX_KEY) begin
                  r_key_valid <= 1'b1;
                  r_cph_start <= 1'b1;
                  r_state     <= S_CRYPT;
                end else if (!r_mode[1]) begin
                  // Key is being replaced, so the held one is no longer usable.
                  r_key_valid <= 1'b0;
                  r_state     <= S_RX_KEY;
                end else if (r_key_valid) begin
                  r_cph_start <= 1'b1;
                  r_state     <= S_CRYPT;
                end else begin
                  r_err_code  <= 8'hE1;
                  r_frame_err <= 1'b1;
                  r_txph      <= 1'b0;
                  r_state     <= S_TX_ERR;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end else if (r_gap == C_TIMEOUT) begin
            r_err_code  <= 8'hE2;
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_txph      <= 1'b0;
            r_state     <= S_TX_ERR;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_CRYPT: begin
          if (i_cph_done) begin
            r_msg   <= i_cph_out;
            r_cnt   <= '0;
            r_txph  <= 1'b0;
            r_state <= S_TX_RESP;
          end else if (r_cnt == C_WDOG_LAST) begin
            r_err_code  <= 8'hE3;
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_txph      <= 1'b0;
            r_state     <= S_TX_ERR;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_TX_RESP, S_TX_ERR: begin
          if (!r_txph) begin
            if (!i_tx_busy) begin
              r_tx_start <= 1'b1;
              r_txph     <= 1'b1;
              r_cnt      <= r_cnt + CW'(1);
              if (r_state == S_TX_ERR) begin
                r_tx_data <= r_err_code;
              end else if (r_cnt == '0) begin
                r_tx_data <= 8'hA0 | {6'b000000, r_mode};
              end else begin
                r_tx_data <= r_msg[BLOCK_W-1 -: 8];
                r_msg     <= {r_msg[BLOCK_W-9:0], 8'h00};
              end
            end
          end else if (i_tx_busy) begin
            // The transmitter has taken the byte; leave once the last one is accepted.
            r_txph <= 1'b0;
            if (r_cnt == w_tx_total) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_cph_in      = r_msg;
  assign o_cph_key     = r_key;
  assign o_cph_decrypt = r_mode[0];
  assign o_cph_start   = r_cph_start;
  assign o_key_valid   = r_key_valid;
  assign o_frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cipher_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cipher_framer
// Description : Scoreboard bench for uart_cipher_framer with a stub cipher
//               core, a busy-modelling transmitter and a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cipher_framer;
  localparam int BW = 64;
  localparam int NX = 10;
  localparam int TO = 300;
  localparam int WD = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          busy = 1'b0;
  logic [BW-1:0] cph_in, cph_key;
  logic          cph_dec, cph_start;
  logic          done = 1'b0, stray_done = 1'b0;
  logic [BW-1:0] cout = '0;
  logic          key_valid, frame_err;

  uart_cipher_framer #(.BLOCK_W(BW), .CHUNK_BITS(7), .TIMEOUT_CYC(TO), .CPH_WDOG(WD)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(busy),
    .o_cph_in(cph_in), .o_cph_key(cph_key), .o_cph_decrypt(cph_dec),
    .o_cph_start(cph_start), .i_cph_done(done | stray_done), .i_cph_out(cout),
    .o_key_valid(key_valid), .o_frame_err(frame_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Stub cipher: a keyed rotate/xor, invertible so decrypt undoes encrypt.
  function automatic logic [63:0] enc(logic [63:0] m, logic [63:0] k);
    logic [63:0] x;
    x = m ^ k;
    return {x[52:0], x[63:53]} ^ {k[31:0], k[63:32]};
  endfunction
  function automatic logic [63:0] dec(logic [63:0] c, logic [63:0] k);
    logic [63:0] y;
    y = c ^ {k[31:0], k[63:32]};
    return {y[10:0], y[63:11]} ^ k;
  endfunction

  // k-th rx payload byte of a block: 7 bits per byte MSB first, remainder last.
  function automatic logic [7:0] chunk(logic [63:0] v, int k);
    int w, lo;
    w  = (k == NX - 1) ? (BW - 7 * (NX - 1)) : 7;
    lo = BW - 7 * k - w;
    return 8'((v >> lo) & ((64'd1 << w) - 64'd1));
  endfunction

  // Scoreboard and model state
  logic [7:0]  exp_q[$];
  int          err_exp = 0, err_seen = 0;
  bit          kv = 1'b0;
  logic [63:0] km = '0;
  bit          start_pending = 1'b0;
  int          exp_start_cyc = 0;
  int          lat = 5;

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        chk("tx_start_while_busy", busy, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      if (cph_start) begin
        chk("cph_start_expected", start_pending, 1);
        chk("cph_start_latency", cyc, exp_start_cyc);
        start_pending = 1'b0;
      end
      if (frame_err) err_seen++;
    end
  end

  // Transmitter: busy rises 1..3 cycles after tx_start, stays 1..5 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Cipher stub with programmable latency (negative = never answers).
  initial begin
    logic [63:0] m, k;
    logic        d;
    forever begin
      @(negedge clk);
      if (cph_start && rst_n) begin
        m = cph_in; k = cph_key; d = cph_dec;
        if (lat >= 0) begin
          repeat (lat) @(negedge clk);
          chk("cph_in_stable", cph_in, m);
          chk("cph_key_stable", cph_key, k);
          cout = d ? dec(m, k) : enc(m, k);
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(logic [7:0] b, bit mark);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (mark) begin
      exp_start_cyc = cyc + 1;
      start_pending = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Full frame; wd=1 means the cipher will never answer.
  task automatic run_frame(logic [7:0] hdr, logic [63:0] msg, logic [63:0] key, bit wd);
    bit          reuse, err1;
    logic [63:0] res;
    reuse = hdr[1];
    err1  = reuse && !kv;
    if (err1) begin
      exp_q.push_back(8'hE1);
      err_exp++;
    end else begin
      if (!reuse) begin km = key; kv = 1'b1; end
      if (wd) begin
        exp_q.push_back(8'hE3);
        err_exp++;
      end else begin
        res = hdr[0] ? dec(msg, km) : enc(msg, km);
        exp_q.push_back(8'hA0 | {6'd0, hdr[1:0]});
        for (int i = 0; i < 8; i++) exp_q.push_back(res[63 - 8 * i -: 8]);
      end
    end
    send_byte(hdr, 1'b0);
    for (int i = 0; i < NX; i++) send_byte(chunk(msg, i), (i == NX - 1) && reuse && !err1);
    if (!reuse)
      for (int i = 0; i < NX; i++) send_byte(chunk(key, i), i == NX - 1);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !start_pending) break;
    end
    repeat (20) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_key_valid"}, key_valid, kv);
    chk({tag, "_frame_err_count"}, err_seen, err_exp);
    chk({tag, "_start_pending"}, start_pending, 0);
  endtask

  initial begin
    logic [63:0] m, k, c;
    logic [7:0]  h;
    #3;
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_cph_start", cph_start, 0);
    chk("reset_cph_in", cph_in, 0);
    chk("reset_cph_key", cph_key, 0);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Stray data bytes and a stray cph_done in IDLE are ignored.
    send_byte(8'h35, 1'b0);
    send_byte(8'h7F, 1'b0);
    @(negedge clk); stray_done = 1'b1; @(negedge clk); stray_done = 1'b0;

    // Encrypt with a new key, then decrypt reusing it.
    m = {$urandom, $urandom}; k = {$urandom, $urandom};
    lat = 37;
    run_frame(8'h80, m, k, 1'b0);
    wait_idle("enc");
    c = enc(m, k);
    lat = 4;
    run_frame(8'h83, c, '0, 1'b0);
    wait_idle("dec_reuse");

    // Watchdog: cipher never answers; key still loaded.
    lat = -1;
    run_frame(8'h80, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    wait_idle("wdog");
    lat = 2;

    // Reset mid-frame, then a reuse request without a key.
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midreset_key_valid", key_valid, 0);
    chk("midreset_cph_key", cph_key, 0);
    kv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_frame(8'h82, {$urandom, $urandom}, '0, 1'b0);
    wait_idle("no_key");

    // Inter-byte timeout inside a frame, then a normal frame.
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h2A, 1'b0);
    exp_q.push_back(8'hE2);
    err_exp++;
    wait_idle("timeout");
    run_frame(8'h80, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    wait_idle("after_timeout");

    // Resync: partial frame interrupted by a new header.
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h11, 1'b0);
    run_frame(8'h81, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    wait_idle("resync");

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      h   = 8'h80 | 8'($urandom_range(0, 127));
      lat = $urandom_range(0, 60);
      run_frame(h, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      wait_idle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1);
  end
endmodule
`default_nettype wire
